// File: rtl/alu_data_port_if.sv
// Bundled handshake and ALU-side signals for the byte-to-serial data port.
// The slave view belongs to the port; the master view belongs to whoever drives it.
interface alu_data_port_if #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) ();
  logic                start;
  logic                pair;
  logic                need_input;
  logic                writeback;
  logic [REG_BITS-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [REG_BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                active;
  logic [NSHIFT-1:0]   data_in1;
  logic [NSHIFT-1:0]   data_in2;
  logic [NSHIFT-1:0]   data_out;
  logic                busy;

  modport slave (
    input  start, pair, need_input, writeback,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    input  active, data_out,
    output data_in1, data_in2,
    output busy
  );

  modport master (
    output start, pair, need_input, writeback,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    output active, data_out,
    input  data_in1, data_in2,
    input  busy
  );
endinterface

// File: rtl/alu_data_port.sv
// Byte-wide to bit-serial bridge: loads operand bytes, streams them to the ALU
// NSHIFT bits per active step while capturing the result, then returns result bytes.
module alu_data_port #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_data_port_if.slave    bus
);

  localparam int WORD         = 2 * REG_BITS;
  localparam int SINGLE_STEPS = REG_BITS / NSHIFT;
  localparam int PAIR_STEPS   = WORD / NSHIFT;
  localparam int SW           = $clog2(PAIR_STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t          state_reg, state_next;
  logic            pair_reg, pair_next;
  logic            wb_reg, wb_next;
  logic            bcnt_reg, bcnt_next;
  logic [SW-1:0]   step_reg, step_next;
  logic [WORD-1:0] opnd_reg, opnd_next;
  logic [WORD-1:0] res_reg, res_next;
  logic [WORD-1:0] opnd_loaded;
  logic [SW-1:0]   last_step;

  assign last_step = pair_reg ? SW'(PAIR_STEPS - 1) : SW'(SINGLE_STEPS - 1);

  // Operand word with the incoming byte dropped into slot bcnt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign opnd_loaded[gi*REG_BITS +: REG_BITS] =
        (bcnt_reg == 1'(gi)) ? bus.in_data : opnd_reg[gi*REG_BITS +: REG_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pair_reg  <= 1'b0;
      wb_reg    <= 1'b0;
      bcnt_reg  <= 1'b0;
      step_reg  <= '0;
      opnd_reg  <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
      wb_reg    <= wb_next;
      bcnt_reg  <= bcnt_next;
      step_reg  <= step_next;
      opnd_reg  <= opnd_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pair_next  = pair_reg;
    wb_next    = wb_reg;
    bcnt_next  = bcnt_reg;
    step_next  = step_reg;
    opnd_next  = opnd_reg;
    res_next   = res_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          pair_next = bus.pair;
          wb_next   = bus.writeback;
          bcnt_next = 1'b0;
          step_next = '0;
          res_next  = '0;
          if (!bus.need_input) begin
            opnd_next = '0;
          end
          state_next = bus.need_input ? ST_LOAD : ST_STREAM;
        end
      end

      ST_LOAD: begin
        if (bus.in_valid) begin
          opnd_next = opnd_loaded;
          // Slot 0 is last for a single transfer, slot 1 for a pair.
          if (bcnt_reg == pair_reg) begin
            bcnt_next  = 1'b0;
            state_next = ST_STREAM;
          end else begin
            bcnt_next = bcnt_reg + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (bus.active) begin
          opnd_next = {{NSHIFT{1'b0}}, opnd_reg[WORD-1:NSHIFT]};
          res_next  = {bus.data_out, res_reg[WORD-1:NSHIFT]};
          step_next = step_reg + 1'b1;
          if (step_reg == last_step) begin
            state_next = wb_reg ? ST_DRAIN : ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (bcnt_reg == pair_reg) begin
            bcnt_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            bcnt_next = bcnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A single transfer's captured byte sits in the upper half of res.
  assign bus.out_data  = (pair_reg && !bcnt_reg) ? res_reg[REG_BITS-1:0]
                                                 : res_reg[WORD-1:REG_BITS];
  assign bus.in_ready  = (state_reg == ST_LOAD);
  assign bus.out_valid = (state_reg == ST_DRAIN);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.data_in1  = opnd_reg[NSHIFT-1:0];
  assign bus.data_in2  = opnd_reg[NSHIFT-1:0];

endmodule
